// File: rtl/vic_cc_stack.sv
// rtl/vic_cc_stack.sv - interrupt context stack saving {condition codes, return PC} per nesting level
// Nested depth is enabled by defining VIC_CC_NESTING_EN; otherwise a single save register is used.
module vic_cc_stack #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_IRQ_Ack,
    input  logic [3:0]          i_CCodes,
    input  logic [PC_WIDTH-1:0] i_PC,
    input  logic                i_RETI,
    input  logic                i_Err_Clr,
    output logic                ro_VIC_CCodes_ctrl,
    output logic [3:0]          ro_VIC_CCodes,
    output logic [PC_WIDTH-1:0] ro_Ret_PC,
    output logic                ro_Ret_Valid,
    output logic [4:0]          ro_Depth,
    output logic                ro_Full,
    output logic                ro_Empty,
    output logic                ro_Ovf_Err,
    output logic                ro_Unf_Err
);

`ifdef VIC_CC_NESTING_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] EFF_D5 = 5'(EFF_DEPTH);

    typedef enum logic {S_IDLE, S_RESTORE} state_t;

    state_t              state;
    logic [3:0]          mem_cc [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc [DEPTH];

    logic          do_push, do_pop, do_tail, push_ovf, pop_unf;
    logic [4:0]    depth_nxt;
    logic [AW-1:0] wr_idx, top_idx;

    // Request decode; a simultaneous push+pop on a non-empty stack is a tail-chain overwrite
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_tail  = 1'b0;
        push_ovf = 1'b0;
        pop_unf  = 1'b0;
        wr_idx   = ro_Depth[AW-1:0];
        top_idx  = AW'(ro_Depth - 5'd1);
        if (i_IRQ_Ack && i_RETI) begin
            if (!ro_Empty) begin
                do_tail = 1'b1;
            end else begin
                do_push = 1'b1;
                pop_unf = 1'b1;
            end
        end else if (i_IRQ_Ack) begin
            if (ro_Full) push_ovf = 1'b1;
            else         do_push  = 1'b1;
        end else if (i_RETI) begin
            if (ro_Empty) pop_unf = 1'b1;
            else          do_pop  = 1'b1;
        end
        depth_nxt = ro_Depth;
        if (do_push)     depth_nxt = ro_Depth + 5'd1;
        else if (do_pop) depth_nxt = ro_Depth - 5'd1;
    end

    // Entry storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_cc[wr_idx] <= i_CCodes;
            mem_pc[wr_idx] <= i_PC;
        end else if (do_tail) begin
            mem_cc[top_idx] <= i_CCodes;
            mem_pc[top_idx] <= i_PC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            ro_Depth           <= 5'd0;
            ro_Full            <= 1'b0;
            ro_Empty           <= 1'b1;
            ro_Ovf_Err         <= 1'b0;
            ro_Unf_Err         <= 1'b0;
            ro_VIC_CCodes_ctrl <= 1'b0;
            ro_Ret_Valid       <= 1'b0;
            ro_VIC_CCodes      <= 4'd0;
            ro_Ret_PC          <= '0;
        end else begin
            ro_Depth   <= depth_nxt;
            ro_Full    <= (depth_nxt == EFF_D5);
            ro_Empty   <= (depth_nxt == 5'd0);
            ro_Ovf_Err <= push_ovf | (ro_Ovf_Err & ~i_Err_Clr);
            ro_Unf_Err <= pop_unf  | (ro_Unf_Err & ~i_Err_Clr);
            // A pop taken while already in RESTORE re-enters RESTORE with the next entry
            case (state)
                S_IDLE, S_RESTORE: begin
                    if (do_pop) begin
                        state              <= S_RESTORE;
                        ro_VIC_CCodes_ctrl <= 1'b1;
                        ro_Ret_Valid       <= 1'b1;
                        ro_VIC_CCodes      <= mem_cc[top_idx];
                        ro_Ret_PC          <= mem_pc[top_idx];
                    end else begin
                        state              <= S_IDLE;
                        ro_VIC_CCodes_ctrl <= 1'b0;
                        ro_Ret_Valid       <= 1'b0;
                        ro_VIC_CCodes      <= 4'd0;
                        ro_Ret_PC          <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vic_cc_stack.md
VIC_CC_STACK -- requirements
Module: vic_cc_stack

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of nested interrupt context entries (2..16).
REQ-002 The module SHALL have parameter PC_WIDTH, default 32, giving the return-address width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_IRQ_Ack  input  1  interrupt entry accepted this cycle (push request).
REQ-006 i_CCodes  input  4  current ALU condition codes {OVERFLOW,CARRY,NEGATIVE,ZERO} (bit 0 = ZERO).
REQ-007 i_PC  input  PC_WIDTH  return address to save on entry.
REQ-008 i_RETI  input  1  return-from-interrupt executed this cycle (pop request).
REQ-009 i_Err_Clr  input  1  clears sticky error flags.
REQ-010 ro_VIC_CCodes_ctrl  output  1  one-cycle restore strobe to the ALU condition-code register.
REQ-011 ro_VIC_CCodes  output  4  condition codes to restore, valid while ro_VIC_CCodes_ctrl=1.
REQ-012 ro_Ret_PC  output  PC_WIDTH  restored return address, valid while ro_Ret_Valid=1.
REQ-013 ro_Ret_Valid  output  1  one-cycle strobe, coincident with ro_VIC_CCodes_ctrl.
REQ-014 ro_Depth  output  5  number of stored entries.
REQ-015 ro_Full, ro_Empty  output  1 each  stack full / empty status.
REQ-016 ro_Ovf_Err, ro_Unf_Err  output  1 each  sticky overflow / underflow error flags.

Function
REQ-017 Push: i_IRQ_Ack=1, i_RETI=0, not full SHALL store {i_CCodes,i_PC} at the top and increment ro_Depth at the same edge.
REQ-018 Pop: i_RETI=1, i_IRQ_Ack=0, not empty SHALL move the FSM IDLE->RESTORE and decrement ro_Depth at the same edge.
REQ-019 In RESTORE, ro_VIC_CCodes_ctrl and ro_Ret_Valid SHALL be 1 for exactly one cycle, carrying the popped entry; the FSM SHALL return to IDLE at the next edge. Latency: i_RETI in cycle N produces the strobes in cycle N+1, so the ALU captures the codes at the end of N+1.
REQ-020 A push or pop arriving while in RESTORE SHALL be processed normally, and the RESTORE strobe SHALL still be issued.
REQ-021 Tail-chain: i_IRQ_Ack=1 and i_RETI=1 in the same cycle with ro_Empty=0 SHALL overwrite the top entry with {i_CCodes,i_PC}, leave ro_Depth unchanged, and issue no restore strobe.
REQ-022 Simultaneous push and pop with ro_Empty=1 SHALL be treated as a push only and SHALL set ro_Unf_Err.
REQ-023 A push while ro_Full=1 SHALL be discarded and SHALL set ro_Ovf_Err; the stored contents and ro_Depth SHALL stay unchanged.
REQ-024 A pop while ro_Empty=1 SHALL set ro_Unf_Err, issue no strobe, and keep ro_Depth at 0.
REQ-025 ro_Full SHALL equal (ro_Depth==DEPTH) and ro_Empty SHALL equal (ro_Depth==0); both SHALL be registered-consistent with ro_Depth.
REQ-026 Error flags SHALL stay set until i_Err_Clr=1. When i_Err_Clr and a new error occur in the same cycle, the flag SHALL be set.
REQ-027 ro_VIC_CCodes and ro_Ret_PC SHALL be 0 whenever their strobe is 0.

Reset
REQ-028 reset=0 SHALL, asynchronously, set the FSM to IDLE, ro_Depth=0, ro_Empty=1, ro_Full=0, all strobes 0, ro_VIC_CCodes=0, ro_Ret_PC=0, and both error flags 0.
REQ-029 Reset during RESTORE SHALL suppress the pending strobe. Stored entry contents need not be cleared.
REQ-030 Release of reset SHALL take effect on the first rising clk edge after reset returns to 1.

Configuration
REQ-031 With macro VIC_CC_NESTING_EN defined, the stack SHALL hold DEPTH entries as specified above.
REQ-032 Without VIC_CC_NESTING_EN, effective depth SHALL be 1 regardless of DEPTH: a single save register, ro_Full=1 after one push, and a second push setting ro_Ovf_Err.

Verification
REQ-033 Reset, then push {CC=4'b1010, PC=0x100}, then i_RETI -> in the next cycle ctrl=1, CCodes=4'b1010, Ret_PC=0x100 for one cycle, and Depth goes 1->0.
REQ-034 Pushes of CC 1,2,3,4 (PC 0x10..0x40), then 4 pops -> strobes return CC 4,3,2,1 in order; Full=1 after the 4th push; Empty=1 at the end.
REQ-035 With Depth=4, a 5th push of CC=4'hF -> Ovf_Err=1, Depth stays 4, and the next pop returns CC=4.
REQ-036 Pop on an empty stack -> Unf_Err=1 and no strobe; i_Err_Clr=1 -> Unf_Err=0 in the next cycle.
REQ-037 With Depth=2 (top CC=5), simultaneous push CC=9/PC=0x200 and RETI -> Depth=2 and no strobe; the next pop returns CC=9, PC=0x200.
REQ-038 Build without VIC_CC_NESTING_EN, push twice -> Full=1 after the first push and Ovf_Err=1 after the second; assert reset=0 mid-RESTORE -> no strobe and Depth=0.
